// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, instruction-type codes and fetch buffer entry type
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    ITYPE_R,
    ITYPE_I,
    ITYPE_S,
    ITYPE_B,
    ITYPE_U,
    ITYPE_J,
    ITYPE_N
  } instr_type_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc, instr} fetch buffer with push/pop/flush and occupancy count
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush wins over everything issued in the same cycle.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I fetch stage: PC, single-outstanding imem reads, fetch buffer to decode
// Optional fetch_count pop counter enabled by defining IFETCH_PERF_CNT_EN.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e       state;
  state_e       state_nxt;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         drop;
  logic [31:0]  redirect_tgt;
  logic [CW-1:0] fifo_count;
  logic         fifo_push;
  logic         fifo_pop;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // No request is in flight in IDLE, so the FIFO count alone decides whether a slot is free.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (redirect_valid || (fifo_count < DEPTH_CNT)) state_nxt = REQ;
      REQ:     if (imem_gnt) state_nxt = WAIT;
      WAIT:    if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_addr holds the issued address so a redirect can move pc without disturbing a pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc       <= redirect_tgt;
            req_addr <= redirect_tgt;
          end else if (state_nxt == REQ) begin
            req_addr <= pc;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            pc   <= redirect_tgt;
            drop <= 1'b1;
          end else if (imem_gnt && !drop) begin
            pc <= pc + 32'd4;
          end
        end
        WAIT: begin
          if (redirect_valid) pc <= redirect_tgt;
          if (imem_rvalid)         drop <= 1'b0;
          else if (redirect_valid) drop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fifo_push        = (state == WAIT) && imem_rvalid && !drop && !redirect_valid;
  assign fifo_pop         = id_valid && id_ready;
  assign push_entry.pc    = req_addr;
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head     (head_entry),
    .count    (fifo_count)
  );

  assign imem_req  = (state == REQ);
  assign imem_addr = req_addr;
  assign id_valid  = (fifo_count != '0);
  assign id_instr  = head_entry.instr;
  assign id_pc     = head_entry.pc;
  assign id_opcode = head_entry.instr[6:0];
  assign id_funct3 = head_entry.instr[14:12];

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fetch_count <= 32'd0;
    else if (fifo_pop && !redirect_valid) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized fetch-stage bench with a queue-based reference model
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  instr_fetch #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_opcode     (id_opcode),
    .id_funct3     (id_funct3)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // stimulus knobs and memory model
  int          gnt_pct, lat_min, lat_max, rdy_pct, rd_pct;
  bit          want_rd_wait, want_rd_req, rd_fire;
  logic [31:0] rd_target;
  int          rd_mark;
  bit          m_busy;
  int          m_cnt;
  logic [31:0] m_addr;
  logic [31:0] gaddr[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic [6:0]  pop_op[$];
  logic [2:0]  pop_f3[$];
  int          n_pop;

  task automatic step();
    bit was_busy;
    bit rd_req_now;
    @(posedge clk);
    #1;
    if (rd_fire) begin
      chk("id_valid_after_redirect", {31'd0, id_valid}, 32'd0);
      rd_fire = 1'b0;
    end
    imem_rvalid    = 1'b0;
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    imem_rdata     = $urandom;
    was_busy       = m_busy;
    if (m_busy) begin
      if (m_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_addr);
        m_busy      = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    rd_req_now = want_rd_req && imem_req && !m_busy;
    if (imem_req && !m_busy && !rd_req_now && ($urandom_range(99) < gnt_pct)) begin
      imem_gnt = 1'b1;
      m_busy   = 1'b1;
      m_addr   = imem_addr;
      m_cnt    = $urandom_range(lat_max, lat_min) - 1;
      gaddr.push_back(imem_addr);
    end
    id_ready = ($urandom_range(99) < rdy_pct);
    if (rd_req_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = rd_target;
      rd_mark        = gaddr.size();
      want_rd_req    = 1'b0;
      rd_fire        = 1'b1;
    end else if (want_rd_wait && was_busy && !imem_rvalid) begin
      redirect_valid = 1'b1;
      redirect_pc    = rd_target;
      rd_mark        = gaddr.size();
      want_rd_wait   = 1'b0;
      rd_fire        = 1'b1;
    end else if ($urandom_range(99) < rd_pct) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
      if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    end
    if (id_valid && id_ready && !redirect_valid) begin
      n_pop++;
      pop_pc.push_back(id_pc);
      pop_instr.push_back(id_instr);
      pop_op.push_back(id_opcode);
      pop_f3.push_back(id_funct3);
    end
  endtask

  task automatic chk_gaddr(input string name, input int idx, input logic [31:0] exp);
    if (idx >= gaddr.size()) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_grant required=%h", name, exp);
    end else begin
      chk(name, gaddr[idx], exp);
    end
  endtask

  // reference model: next fetch address, one in-flight read, ordered buffer of delivered words
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] next_addr;
  logic [31:0] resp_addr;
  bit          outstanding, resp_stale, pend_stale, prev_pend;
  logic [31:0] prev_addr;
  int          idle_run;
  logic [31:0] fetch_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      next_addr   = RESET_PC;
      outstanding = 1'b0;
      resp_stale  = 1'b0;
      pend_stale  = 1'b0;
      prev_pend   = 1'b0;
      idle_run    = 0;
      fetch_cnt   = 32'd0;
    end else begin
      bit m_pop;
      chk("id_valid", {31'd0, id_valid}, {31'd0, q.size() != 0});
      if (id_valid && q.size() != 0) begin
        chk("id_pc", id_pc, q[0].pc);
        chk("id_instr", id_instr, q[0].instr);
        chk("id_opcode", {25'd0, id_opcode}, {25'd0, q[0].instr[6:0]});
        chk("id_funct3", {29'd0, id_funct3}, {29'd0, q[0].instr[14:12]});
      end
      if (outstanding) chk("req_while_outstanding", {31'd0, imem_req}, 32'd0);
      if (prev_pend) begin
        chk("req_held", {31'd0, imem_req}, 32'd1);
        chk("addr_stable", imem_addr, prev_addr);
      end
      if (!imem_req && !outstanding && q.size() < DEPTH) idle_run++;
      else idle_run = 0;
      chk("request_liveness", {31'd0, idle_run <= 2}, 32'd1);
`ifdef IFETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, fetch_cnt);
`endif
      prev_pend = imem_req && !imem_gnt;
      prev_addr = imem_addr;

      m_pop = (q.size() != 0) && id_ready && !redirect_valid;
      if (m_pop) begin
        void'(q.pop_front());
        fetch_cnt = fetch_cnt + 32'd1;
      end
      if (imem_rvalid) begin
        if (!resp_stale && !redirect_valid) q.push_back('{pc: resp_addr, instr: mem_word(resp_addr)});
        outstanding = 1'b0;
        resp_stale  = 1'b0;
      end
      if (imem_req && imem_gnt) begin
        if (!pend_stale) chk("grant_addr", imem_addr, next_addr);
        resp_addr   = next_addr;
        resp_stale  = pend_stale || redirect_valid;
        outstanding = 1'b1;
        if (!pend_stale) next_addr = next_addr + 32'd4;
        pend_stale  = 1'b0;
      end
      if (redirect_valid) begin
        next_addr = redirect_pc & 32'hFFFF_FFFC;
        q.delete();
        if (imem_req && !imem_gnt) pend_stale = 1'b1;
        else if (outstanding) resp_stale = 1'b1;
      end
      chk("capacity", {31'd0, (q.size() + int'(outstanding)) <= DEPTH}, 32'd1);
    end
  end

  initial begin
    int pops0;
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    m_busy = 1'b0; m_cnt = 0; m_addr = '0; n_pop = 0;
    want_rd_wait = 1'b0; want_rd_req = 1'b0; rd_fire = 1'b0; rd_mark = 0; rd_target = '0;
    gnt_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 100; rd_pct = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_imem_req", {31'd0, imem_req}, 32'd0);
    chk("reset_id_valid", {31'd0, id_valid}, 32'd0);
    chk("reset_imem_addr", imem_addr, RESET_PC);
`ifdef IFETCH_PERF_CNT_EN
    chk("reset_fetch_count", fetch_count, 32'd0);
`endif
    rst_n = 1'b1;

    // in-order fetch with immediate grant and one-cycle data
    repeat (15) step();
    chk_gaddr("first_grant", 0, 32'h0);
    chk_gaddr("second_grant", 1, 32'h4);
    chk_gaddr("third_grant", 2, 32'h8);
    if (pop_pc.size() < 2) begin
      checks++; errors++;
      $display("FAIL first_pops actual=%0d required=2", pop_pc.size());
    end else begin
      chk("pop0_pc", pop_pc[0], 32'h0);
      chk("pop0_opcode", {25'd0, pop_op[0]}, 32'h13);
      chk("pop1_pc", pop_pc[1], 32'h4);
      chk("pop1_instr", pop_instr[1], 32'h78DD_E6D7);
      chk("pop1_opcode", {25'd0, pop_op[1]}, 32'h57);
      chk("pop1_funct3", {29'd0, pop_f3[1]}, 32'd6);
    end

    // decode stalled: buffer fills to DEPTH and the requester goes quiet
    rdy_pct = 0;
    repeat (12) step();
    chk("stall_imem_req", {31'd0, imem_req}, 32'd0);
    chk("stall_id_valid", {31'd0, id_valid}, 32'd1);
    gnt_pct = 0; rdy_pct = 100;
    pops0 = n_pop;
    repeat (6) step();
    chk("stall_buffered_words", 32'(n_pop - pops0), 32'd2);

    // redirect while a read is in flight
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    rd_target = 32'h100; want_rd_wait = 1'b1;
    repeat (25) step();
    chk("rd_wait_fired", {31'd0, want_rd_wait}, 32'd0);
    chk_gaddr("rd_wait_next_addr", rd_mark, 32'h100);

    // redirect with the request still ungranted; pending request completes and is dropped
    lat_min = 1; lat_max = 2;
    rd_target = 32'h203; want_rd_req = 1'b1;
    repeat (25) step();
    chk("rd_req_fired", {31'd0, want_rd_req}, 32'd0);
    chk_gaddr("rd_req_next_addr", rd_mark + 1, 32'h200);

    // fetch of the last word in the address space wraps the PC
    lat_min = 2; lat_max = 3;
    rd_target = 32'hFFFF_FFFC; want_rd_wait = 1'b1;
    repeat (25) step();
    chk("wrap_fired", {31'd0, want_rd_wait}, 32'd0);
    chk_gaddr("wrap_top_addr", rd_mark, 32'hFFFF_FFFC);
    chk_gaddr("wrap_next_addr", rd_mark + 1, 32'h0);

    // randomized traffic
    gnt_pct = 60; lat_min = 1; lat_max = 4; rdy_pct = 50; rd_pct = 4;
    repeat (3000) step();
    rd_pct = 0; rdy_pct = 100; gnt_pct = 100;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
